uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter: the transmit half of the terminal's serial link, the counterpart of the existing `uart_rx`. It accepts bytes from on-chip logic (keyboard scanner, status/echo logic) through a valid/ready push port and queues them in a 16-entry FIFO. It serialises them on `ser_tx` (wired to `ftdi_rxd` at top level) at the same `cfg_divider` bit rate the receiver uses. Running on `clk_25mhz` with `cfg_divider = 217` gives 115200 baud.

---
 rtl/uart_tx_fifo_if.sv | 9 +
 rtl/uart_tx_fifo.sv | 158 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte push port of the buffered UART transmitter: producer drives data/valid, FIFO returns ready.
interface uart_tx_fifo_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: 2^DEPTH_LOG2-entry FIFO, push-to-line 2 clocks, ready low when full (push dropped).
// Define UART_TX_CRLF_EN to follow every transmitted 8'h0D with an automatic 8'h0A frame.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         cfg_divider,
  uart_tx_fifo_if.slave       push,
  output logic                ser_tx,
  output logic                busy,
  output logic [DEPTH_LOG2:0] level
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_TX_CRLF_EN
    , LF
`endif
  } state_t;

  localparam logic [DEPTH_LOG2:0]   FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [7:0]            mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  state_t                state;
  logic [31:0]           div_q;
  logic [31:0]           cnt;
  logic [31:0]           eff_div;
  logic [7:0]            shift;
  logic [2:0]            bit_idx;
  logic                  do_push;
  logic                  do_pop;
  logic                  frame_done;
`ifdef UART_TX_CRLF_EN
  logic                  is_cr;
`endif

  assign eff_div    = (cfg_divider < 32'd2) ? 32'd2 : cfg_divider;
  assign push.ready = (level != FULL);
  assign do_push    = push.valid && push.ready;
  assign frame_done = (cnt == 32'd0);
  assign busy       = (state != IDLE) || (level != '0);

  // A CR frame must be followed by its LF before the next FIFO entry is taken.
  always_comb begin
    do_pop = 1'b0;
    case (state)
      IDLE:    do_pop = (level != '0);
`ifdef UART_TX_CRLF_EN
      STOP:    do_pop = frame_done && (level != '0) && !is_cr;
`else
      STOP:    do_pop = frame_done && (level != '0);
`endif
      default: do_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_ptr] <= push.data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      ser_tx  <= 1'b1;
      div_q   <= 32'd2;
      cnt     <= 32'd0;
      shift   <= 8'h00;
      bit_idx <= 3'd0;
`ifdef UART_TX_CRLF_EN
      is_cr   <= 1'b0;
`endif
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop) begin
        level <= level + LVL_ONE;
      end else if (!do_push && do_pop) begin
        level <= level - LVL_ONE;
      end

      // ser_tx follows the current state, so the line lags the state by one clock.
      case (state)
        IDLE: ser_tx <= 1'b1;
        START: begin
          ser_tx <= 1'b0;
          if (frame_done) begin
            state   <= DATA;
            cnt     <= div_q - 32'd1;
            bit_idx <= 3'd0;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        DATA: begin
          ser_tx <= shift[0];
          if (frame_done) begin
            shift <= shift >> 1;
            cnt   <= div_q - 32'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        STOP: begin
          ser_tx <= 1'b1;
          if (frame_done) begin
            state <= IDLE;
`ifdef UART_TX_CRLF_EN
            if (is_cr) state <= LF;
`endif
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
`ifdef UART_TX_CRLF_EN
        LF: begin
          ser_tx <= 1'b1;
          shift  <= 8'h0A;
          is_cr  <= 1'b0;
          cnt    <= div_q - 32'd1;
          state  <= START;
        end
`endif
        default: state <= IDLE;
      endcase

      // Frame load overrides the IDLE/STOP transition above for gapless frames.
      if (do_pop) begin
        shift   <= mem[rd_ptr];
        div_q   <= eff_div;
        cnt     <= eff_div - 32'd1;
        bit_idx <= 3'd0;
        state   <= START;
`ifdef UART_TX_CRLF_EN
        is_cr   <= (mem[rd_ptr] == 8'h0D);
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised scoreboard bench for uart_tx_fifo: a line decoder checks every frame against queued expectations.
module tb_uart_tx_fifo;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cfg_divider;
  logic        ser_tx;
  logic        busy;
  logic [4:0]  level;
  bit          flush;

  uart_tx_fifo_if push_if ();

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_divider (cfg_divider),
    .push        (push_if),
    .ser_tx      (ser_tx),
    .busy        (busy),
    .level       (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int eff_div(input int c);
    return (c < 2) ? 2 : c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; the push lands on the following posedge.
  task automatic push_byte(input logic [7:0] b, input bit exp_rdy, input int d);
    push_if.data  = b;
    push_if.valid = 1'b1;
    check("push_ready", {31'd0, push_if.ready}, {31'd0, exp_rdy});
    if (exp_rdy) begin
      exp_q.push_back('{b: b, d: d});
`ifdef UART_TX_CRLF_EN
      if (b == 8'h0D) exp_q.push_back('{b: 8'h0A, d: d});
`endif
    end
    @(negedge clk);
    push_if.valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, (n >= budget)}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [9:0] bits;
    logic [7:0] rx;
    bit         bad;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (reset || flush || ser_tx !== 1'b0) continue;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: start bit seen, no byte expected");
        while (ser_tx !== 1'b1 && !flush) @(negedge clk);
      end else begin
        e       = exp_q.pop_front();
        bits    = {1'b1, e.b, 1'b0};
        rx      = 8'h00;
        bad     = 1'b0;
        aborted = 1'b0;
        for (int k = 0; k < 10 * e.d; k++) begin
          if (k > 0) @(negedge clk);
          if (reset || flush) begin
            aborted = 1'b1;
            break;
          end
          if (ser_tx !== bits[k / e.d]) bad = 1'b1;
          if ((k % e.d) == e.d / 2 && k >= e.d && k < 9 * e.d) rx[k / e.d - 1] = ser_tx;
        end
        if (!aborted) begin
          check("frame_byte", {24'd0, rx}, {24'd0, e.b});
          check("frame_shape", {31'd0, bad}, 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int c;
    int nb;
    reset         = 1'b1;
    flush         = 1'b1;
    cfg_divider   = 32'd4;
    push_if.data  = 8'h00;
    push_if.valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ser_tx", {31'd0, ser_tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_level", {27'd0, level}, 32'd0);
    check("reset_ready", {31'd0, push_if.ready}, 32'd1);
    reset = 1'b0;
    flush = 1'b0;
    @(negedge clk);

    // Single byte, divider 4: start bit two clocks after the push edge.
    push_byte(8'h41, 1'b1, 4);
    check("level_after_push", {27'd0, level}, 32'd1);
    @(negedge clk);
    check("tx_high_at_pop", {31'd0, ser_tx}, 32'd1);
    @(negedge clk);
    check("tx_start_latency", {31'd0, ser_tx}, 32'd0);
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("single_frame_span", n + 1, 32'd40);
    wait_idle(200, "single_timeout");

    // Overflow: first byte holds the line for 10000 clocks, 16 more fill the FIFO.
    cfg_divider = 32'd1000;
    for (int i = 0; i < 18; i++) begin
      push_byte(8'(8'h10 + i), (i < 17), (i == 0) ? 1000 : 3);
    end
    check("level_full", {27'd0, level}, 32'd16);
    check("ready_full", {31'd0, push_if.ready}, 32'd0);
    cfg_divider = 32'd3;
    wait_idle(20000, "overflow_timeout");

    // Back-to-back frames at 115200 baud spacing.
    cfg_divider = 32'd217;
    push_byte(8'h55, 1'b1, 217);
    push_byte(8'hAA, 1'b1, 217);
    n = 0;
    while (ser_tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (busy && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("b2b_span", n + 1, 32'd4340);
    wait_idle(6000, "b2b_timeout");

    // Divider clamp.
    cfg_divider = 32'd0;
    push_byte(8'hA5, 1'b1, 2);
    wait_idle(200, "clamp0_timeout");
    cfg_divider = 32'd1;
    push_byte(8'h3C, 1'b1, 2);
    wait_idle(200, "clamp1_timeout");

    // CR followed by a normal byte.
    cfg_divider = 32'd4;
    push_byte(8'h0D, 1'b1, 4);
    push_byte(8'h41, 1'b1, 4);
    wait_idle(400, "crlf_timeout");

    // Reset during data bit 3 with five bytes still queued.
    cfg_divider = 32'd8;
    for (int i = 0; i < 6; i++) push_byte(8'(8'hC0 + i), 1'b1, 8);
    repeat (32) @(negedge clk);
    check("level_before_reset", {27'd0, level}, 32'd5);
    reset = 1'b1;
    flush = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midreset_ser_tx", {31'd0, ser_tx}, 32'd1);
    check("midreset_level", {27'd0, level}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_ready", {31'd0, push_if.ready}, 32'd1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b0;
    repeat (50) @(negedge clk);
    check("post_reset_line", {31'd0, ser_tx}, 32'd1);
    check("post_reset_busy", {31'd0, busy}, 32'd0);

    // Random bursts with random dividers and gaps.
    for (int it = 0; it < 30; it++) begin
      c           = $urandom_range(0, 6);
      cfg_divider = c;
      nb          = $urandom_range(1, 6);
      for (int j = 0; j < nb; j++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        push_byte(8'($urandom_range(0, 255)), 1'b1, eff_div(c));
      end
      wait_idle(2000, "random_timeout");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
